mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-access stage of the static pipeline, directly upstream of the data memory.
- Holds the EX/MEM pipeline register and drives the data memory's enable, size, address and write-data signals.
- Size-extends the load data returned by the data memory.
- Checks alignment and address range, then registers the result into the MEM/WB register for write-back.

Parameters:
- DMEM_BYTES, 256, byte depth of the data memory; addresses >= DMEM_BYTES raise an exception.
- ADDR_W, 32, address/data width.

Ports:
- clk  in  1  clock; all registers update on posedge.
- rst  in  1  asynchronous reset, active-high.
- stall  in  1  hold EX/MEM and MEM/WB registers.
- flush  in  1  load a bubble into EX/MEM.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_mem_r  in  2  load size: 00 none, 01 word, 10 half, 11 byte.
- ex_mem_w  in  2  store size, same encoding.
- ex_load_signed  in  1  1 = LB/LH sign-extend; 0 = LBU/LHU zero-extend.
- ex_alu_result  in  32  effective address, or result for non-memory instructions.
- ex_store_data  in  32  rt value; data is right-justified.
- ex_rd  in  5  destination register.
- ex_reg_we  in  1  register write enable.
- dm_ena  out  1  data memory enable.
- dm_w_ena  out  1  data memory write enable.
- dm_w  out  2  store size to the data memory.
- dm_r  out  2  load size to the data memory.
- dm_addr  out  32  byte address.
- dm_wdata  out  32  store data, masked to size.
- dm_rdata  in  32  right-justified read data.
- wb_valid  out  1  MEM/WB holds a real instruction.
- wb_rd  out  5  destination register.
- wb_reg_we  out  1  write-back enable.
- wb_data  out  32  loaded or ALU value.
- wb_exc  out  1  address exception.
- wb_badvaddr  out  32  faulting address.

Behaviour:
- Reset: on rst (async), all EX/MEM and MEM/WB fields clear to 0. dm_* outputs become 0 combinationally.
- Register priority at each posedge: rst > stall (both registers hold) > flush (EX/MEM <= bubble) > normal capture.
  - flush with stall: stall wins for this edge; flush must be reasserted by the hazard unit.
- Bubble: valid=0, mem_r=mem_w=00, reg_we=0.
- Latency: an instruction captured into EX/MEM at posedge N appears on wb_* after posedge N+1.
  - The data memory writes at the negedge between those edges; its read is combinational in the same cycle.
- Exception check (combinational on EX/MEM):
  - misaligned = (size word and addr[1:0]!=0) or (size half and addr[0]!=0).
  - out_of_range = addr >= DMEM_BYTES.
  - exc = mem_valid and (mem_r!=00 or mem_w!=00) and (misaligned or out_of_range).
- Data memory drive:
  - dm_ena = mem_valid and (mem_r!=00 or mem_w!=00) and !exc.
  - dm_w_ena = dm_ena and mem_w!=00 and !stall, so a held store never issues a repeated write.
  - dm_r = dm_ena ? mem_r : 00; dm_w = dm_ena ? mem_w : 00; dm_addr = mem_alu_result.
  - dm_wdata = store data masked to 8/16/32 bits, upper bits 0.
- Load extension:
  - byte: signed ? sext(rdata[7:0]) : zext(rdata[7:0]).
  - half: signed ? sext(rdata[15:0]) : zext(rdata[15:0]).
  - word: rdata passes through unchanged.
- MEM/WB capture:
  - wb_data = loaded value if mem_r!=00, else mem_alu_result.
  - wb_reg_we = mem_reg_we and mem_valid and !exc.
  - wb_exc = exc; wb_badvaddr = exc ? address : 0.
- Both mem_r and mem_w nonzero is illegal: the store wins and no load extension is done.
- Bubble in the MEM stage: no data memory access, wb_valid=0.

Optional Feature:
- Macro MEM_FWD_EN.
- Defined: adds the following outputs for the EX bypass network:
  - mem_fwd_valid (1), mem_fwd_rd (5), mem_fwd_data (32): EX/MEM ALU result.
    - mem_fwd_valid = mem_valid and mem_reg_we and mem_r==00 and mem_rd!=0.
  - mem_load_use (1): mem_valid and mem_r!=00 and mem_rd!=0, for the hazard unit to stall.
- Undefined: these ports do not exist; the hazard unit stalls on every RAW dependency.

Test Plan:
- Reset mid-load (rst pulse between edges) -> all wb_* = 0, dm_ena=0 immediately, no clk edge needed.
- SB addr 0x05 data 0x123456A5, then LB addr 0x05 signed -> dm_wdata=0x000000A5; wb_data=0xFFFFFFA5. LBU same address -> 0x000000A5.
- SW addr 0x0E -> wb_exc=1, wb_badvaddr=0x0000000E, dm_ena=0, wb_reg_we=0. LW addr 0x100 -> wb_exc=1 (out of range).
- Store at addr 0x10 with stall held 3 cycles -> exactly one negedge with dm_w_ena=1, in the release cycle; wb_* unchanged during the stall.
- flush with ex_valid=1 (ADD, rd=8) -> next cycle dm_ena=0, following wb_valid=0, wb_reg_we=0. stall+flush same edge -> EX/MEM held.
- MEM_FWD_EN: ADD rd=3 result 0x2A in MEM -> mem_fwd_valid=1, mem_fwd_data=0x2A. LW rd=3 -> mem_load_use=1, mem_fwd_valid=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - EX/MEM + MEM/WB registers, data memory drive, alignment/range check, load extension.
// Optional bypass outputs are compiled in when MEM_FWD_EN is defined.
module mem_stage_lsu #(
   parameter int DMEM_BYTES = 256,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [1:0]        ex_mem_r,
   input  logic [1:0]        ex_mem_w,
   input  logic              ex_load_signed,
   input  logic [ADDR_W-1:0] ex_alu_result,
   input  logic [ADDR_W-1:0] ex_store_data,
   input  logic [4:0]        ex_rd,
   input  logic              ex_reg_we,
   output logic              dm_ena,
   output logic              dm_w_ena,
   output logic [1:0]        dm_w,
   output logic [1:0]        dm_r,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [ADDR_W-1:0] dm_wdata,
   input  logic [ADDR_W-1:0] dm_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic              wb_reg_we,
   output logic [ADDR_W-1:0] wb_data,
   output logic              wb_exc,
   output logic [ADDR_W-1:0] wb_badvaddr
`ifdef MEM_FWD_EN
   ,
   output logic              mem_fwd_valid,
   output logic [4:0]        mem_fwd_rd,
   output logic [ADDR_W-1:0] mem_fwd_data,
   output logic              mem_load_use
`endif
);

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_WORD = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_BYTE = 2'b11;

   logic              mem_valid;
   logic [1:0]        mem_r;
   logic [1:0]        mem_w;
   logic              mem_signed;
   logic [ADDR_W-1:0] mem_alu_result;
   logic [ADDR_W-1:0] mem_store_data;
   logic [4:0]        mem_rd;
   logic              mem_reg_we;

   logic              is_mem;
   logic [1:0]        eff_size;
   logic [1:0]        load_size;
   logic              misaligned;
   logic              out_of_range;
   logic              exc;
   logic [ADDR_W-1:0] load_ext;
   logic [ADDR_W-1:0] wb_data_nxt;

   // EX/MEM register: stall outranks flush, so a flush under stall is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid      <= 1'b0;
         mem_r          <= SZ_NONE;
         mem_w          <= SZ_NONE;
         mem_signed     <= 1'b0;
         mem_alu_result <= '0;
         mem_store_data <= '0;
         mem_rd         <= 5'd0;
         mem_reg_we     <= 1'b0;
      end else if (!stall) begin
         if (flush) begin
            mem_valid      <= 1'b0;
            mem_r          <= SZ_NONE;
            mem_w          <= SZ_NONE;
            mem_signed     <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= 5'd0;
            mem_reg_we     <= 1'b0;
         end else begin
            mem_valid      <= ex_valid;
            mem_r          <= ex_mem_r;
            mem_w          <= ex_mem_w;
            mem_signed     <= ex_load_signed;
            mem_alu_result <= ex_alu_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_reg_we     <= ex_reg_we;
         end
      end
   end

   // A store wins over a simultaneous load, so the load size is suppressed
   always_comb begin
      is_mem       = (mem_r != SZ_NONE) || (mem_w != SZ_NONE);
      eff_size     = (mem_w != SZ_NONE) ? mem_w : mem_r;
      load_size    = (mem_w != SZ_NONE) ? SZ_NONE : mem_r;
      misaligned   = ((eff_size == SZ_WORD) && (mem_alu_result[1:0] != 2'b00)) ||
                     ((eff_size == SZ_HALF) && mem_alu_result[0]);
      out_of_range = mem_alu_result >= ADDR_W'(DMEM_BYTES);
      exc          = mem_valid && is_mem && (misaligned || out_of_range);
   end

   // A held store must not write again, hence the stall term on the write enable
   always_comb begin
      dm_ena   = mem_valid && is_mem && !exc;
      dm_w_ena = dm_ena && (mem_w != SZ_NONE) && !stall;
      dm_r     = dm_ena ? load_size : SZ_NONE;
      dm_w     = dm_ena ? mem_w : SZ_NONE;
      dm_addr  = mem_alu_result;
      dm_wdata = '0;
      case (mem_w)
         SZ_BYTE: dm_wdata = {{(ADDR_W-8){1'b0}},  mem_store_data[7:0]};
         SZ_HALF: dm_wdata = {{(ADDR_W-16){1'b0}}, mem_store_data[15:0]};
         SZ_WORD: dm_wdata = mem_store_data;
         default: dm_wdata = '0;
      endcase
   end

   always_comb begin
      load_ext = dm_rdata;
      case (load_size)
         SZ_BYTE: load_ext = {{(ADDR_W-8){mem_signed & dm_rdata[7]}},   dm_rdata[7:0]};
         SZ_HALF: load_ext = {{(ADDR_W-16){mem_signed & dm_rdata[15]}}, dm_rdata[15:0]};
         default: load_ext = dm_rdata;
      endcase
      wb_data_nxt = (load_size != SZ_NONE) ? load_ext : mem_alu_result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid    <= 1'b0;
         wb_rd       <= 5'd0;
         wb_reg_we   <= 1'b0;
         wb_data     <= '0;
         wb_exc      <= 1'b0;
         wb_badvaddr <= '0;
      end else if (!stall) begin
         wb_valid    <= mem_valid;
         wb_rd       <= mem_rd;
         wb_reg_we   <= mem_reg_we && mem_valid && !exc;
         wb_data     <= wb_data_nxt;
         wb_exc      <= exc;
         wb_badvaddr <= exc ? mem_alu_result : '0;
      end
   end

`ifdef MEM_FWD_EN
   // Loads cannot forward from here; the hazard unit stalls on mem_load_use instead
   assign mem_fwd_valid = mem_valid && mem_reg_we && (mem_r == SZ_NONE) && (mem_rd != 5'd0);
   assign mem_fwd_rd    = mem_rd;
   assign mem_fwd_data  = mem_alu_result;
   assign mem_load_use  = mem_valid && (mem_r != SZ_NONE) && (mem_rd != 5'd0);
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu with a byte-array data memory model.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        ex_valid = 1'b0;
   logic [1:0]  ex_mem_r = 2'b00;
   logic [1:0]  ex_mem_w = 2'b00;
   logic        ex_load_signed = 1'b0;
   logic [31:0] ex_alu_result = '0;
   logic [31:0] ex_store_data = '0;
   logic [4:0]  ex_rd = '0;
   logic        ex_reg_we = 1'b0;
   logic        dm_ena, dm_w_ena;
   logic [1:0]  dm_w, dm_r;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        wb_valid, wb_reg_we, wb_exc;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, wb_badvaddr;
`ifdef MEM_FWD_EN
   logic        mem_fwd_valid, mem_load_use;
   logic [4:0]  mem_fwd_rd;
   logic [31:0] mem_fwd_data;
`endif

   mem_stage_lsu #(.DMEM_BYTES(256), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
      .ex_load_signed(ex_load_signed), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
      .dm_ena(dm_ena), .dm_w_ena(dm_w_ena), .dm_w(dm_w), .dm_r(dm_r),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
      .wb_data(wb_data), .wb_exc(wb_exc), .wb_badvaddr(wb_badvaddr)
`ifdef MEM_FWD_EN
      , .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd),
      .mem_fwd_data(mem_fwd_data), .mem_load_use(mem_load_use)
`endif
   );

   always #5 clk = ~clk;

   bit [7:0] mem [256];
   int       wcount = 0;
   int       n_cmp = 0;
   int       n_bad = 0;

   typedef struct {
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
      logic        exc;
      logic [31:0] bad;
      logic        chk_data;
   } wb_t;
   wb_t sbq[$];

   always_comb begin
      logic [7:0] a;
      a = dm_addr[7:0];
      dm_rdata = '0;
      if (dm_addr < 32'd256) begin
         case (dm_r)
            2'b11: dm_rdata = {24'd0, mem[a]};
            2'b10: dm_rdata = {16'd0, mem[a + 8'd1], mem[a]};
            2'b01: dm_rdata = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
            default: dm_rdata = '0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (dm_w_ena) begin
         logic [7:0] a;
         a = dm_addr[7:0];
         wcount = wcount + 1;
         case (dm_w)
            2'b11: mem[a] = dm_wdata[7:0];
            2'b10: begin mem[a] = dm_wdata[7:0]; mem[a + 8'd1] = dm_wdata[15:8]; end
            2'b01: begin
               mem[a] = dm_wdata[7:0];          mem[a + 8'd1] = dm_wdata[15:8];
               mem[a + 8'd2] = dm_wdata[23:16]; mem[a + 8'd3] = dm_wdata[31:24];
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_wb(input logic [4:0] rd, input logic we, input logic [31:0] data,
                            input logic exc, input logic [31:0] bad, input logic chk_data);
      wb_t e;
      e.rd = rd; e.we = we; e.data = data; e.exc = exc; e.bad = bad; e.chk_data = chk_data;
      sbq.push_back(e);
   endtask

   task automatic issue(input logic [1:0] r, input logic [1:0] w, input logic sgn,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input logic we, input logic fl);
      ex_valid = 1'b1; ex_mem_r = r; ex_mem_w = w; ex_load_signed = sgn;
      ex_alu_result = alu; ex_store_data = sd; ex_rd = rd; ex_reg_we = we; flush = fl;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_mem_r = 2'b00; ex_mem_w = 2'b00; ex_reg_we = 1'b0; flush = 1'b0;
   endtask

   // Monitor: one wb entry per capturing edge that delivers a valid instruction
   initial begin
      forever begin
         logic cap;
         @(posedge clk);
         cap = !stall && !rst;
         @(negedge clk);
         if (cap && wb_valid) begin
            n_cmp++;
            if (sbq.size() == 0) begin
               n_bad++;
               $display("FAIL wb_unexpected: got rd=%0d data=0x%08h, expected no instruction", wb_rd, wb_data);
            end else begin
               wb_t e;
               e = sbq.pop_front();
               if (wb_rd !== e.rd || wb_reg_we !== e.we || wb_exc !== e.exc ||
                   wb_badvaddr !== e.bad || (e.chk_data && wb_data !== e.data)) begin
                  n_bad++;
                  $display("FAIL wb_entry: got rd=%0d we=%0b data=0x%08h exc=%0b bad=0x%08h expected rd=%0d we=%0b data=0x%08h exc=%0b bad=0x%08h",
                           wb_rd, wb_reg_we, wb_data, wb_exc, wb_badvaddr,
                           e.rd, e.we, e.data, e.exc, e.bad);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int w0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("reset_dm_ena", {31'd0, dm_ena}, 32'd0);
      rst = 1'b0;

      // SB then signed/unsigned byte loads
      expect_wb(5'd0, 1'b0, 32'h05, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b11, 1'b0, 32'h05, 32'h123456A5, 5'd0, 1'b0, 1'b0);
      chk("sb_dm_wdata", dm_wdata, 32'h000000A5);
      chk("sb_dm_w_ena", {31'd0, dm_w_ena}, 32'd1);
      expect_wb(5'd4, 1'b1, 32'hFFFFFFA5, 1'b0, 32'h0, 1'b1);
      issue(2'b11, 2'b00, 1'b1, 32'h05, 32'h0, 5'd4, 1'b1, 1'b0);
      chk("lb_dm_r", {30'd0, dm_r}, 32'd3);
      expect_wb(5'd5, 1'b1, 32'h000000A5, 1'b0, 32'h0, 1'b1);
      issue(2'b11, 2'b00, 1'b0, 32'h05, 32'h0, 5'd5, 1'b1, 1'b0);

      // halfword and word round trips
      expect_wb(5'd0, 1'b0, 32'h06, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b10, 1'b0, 32'h06, 32'hDEAD8001, 5'd0, 1'b0, 1'b0);
      chk("sh_dm_wdata", dm_wdata, 32'h00008001);
      expect_wb(5'd6, 1'b1, 32'hFFFF8001, 1'b0, 32'h0, 1'b1);
      issue(2'b10, 2'b00, 1'b1, 32'h06, 32'h0, 5'd6, 1'b1, 1'b0);
      expect_wb(5'd7, 1'b1, 32'h00008001, 1'b0, 32'h0, 1'b1);
      issue(2'b10, 2'b00, 1'b0, 32'h06, 32'h0, 5'd7, 1'b1, 1'b0);
      expect_wb(5'd0, 1'b0, 32'h08, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b01, 1'b0, 32'h08, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0);
      expect_wb(5'd9, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
      issue(2'b01, 2'b00, 1'b0, 32'h08, 32'h0, 5'd9, 1'b1, 1'b0);
      expect_wb(5'd7, 1'b1, 32'h00001234, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd7, 1'b1, 1'b0);

      // last valid byte address
      expect_wb(5'd0, 1'b0, 32'hFF, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b11, 1'b0, 32'hFF, 32'h0000007F, 5'd0, 1'b0, 1'b0);
      expect_wb(5'd2, 1'b1, 32'h0000007F, 1'b0, 32'h0, 1'b1);
      issue(2'b11, 2'b00, 1'b1, 32'hFF, 32'h0, 5'd2, 1'b1, 1'b0);

      // exceptions: misaligned word store, out-of-range load, misaligned half load
      expect_wb(5'd0, 1'b0, 32'h0E, 1'b1, 32'h0000000E, 1'b1);
      issue(2'b00, 2'b01, 1'b0, 32'h0E, 32'h55, 5'd0, 1'b0, 1'b0);
      chk("sw_misaligned_dm_ena", {31'd0, dm_ena}, 32'd0);
      expect_wb(5'd9, 1'b0, 32'h0, 1'b1, 32'h00000100, 1'b0);
      issue(2'b01, 2'b00, 1'b0, 32'h100, 32'h0, 5'd9, 1'b1, 1'b0);
      chk("lw_range_dm_ena", {31'd0, dm_ena}, 32'd0);
      expect_wb(5'd9, 1'b0, 32'h0, 1'b1, 32'h00000003, 1'b0);
      issue(2'b10, 2'b00, 1'b1, 32'h03, 32'h0, 5'd9, 1'b1, 1'b0);

      // store held by a 3-cycle stall writes exactly once
      expect_wb(5'd10, 1'b1, 32'h55, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b00, 1'b0, 32'h55, 32'h0, 5'd10, 1'b1, 1'b0);
      expect_wb(5'd0, 1'b0, 32'h10, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b01, 1'b0, 32'h10, 32'h11223344, 5'd0, 1'b0, 1'b0);
      stall = 1'b1;
      w0 = wcount;
      #1;
      chk("stall_dm_w_ena", {31'd0, dm_w_ena}, 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_wb_rd", {27'd0, wb_rd}, 32'd10);
         chk("stall_wb_data", wb_data, 32'h55);
      end
      stall = 1'b0;
      @(posedge clk); #1;
      chk("stall_write_count", wcount - w0, 32'd1);
      expect_wb(5'd6, 1'b1, 32'h11223344, 1'b0, 32'h0, 1'b1);
      issue(2'b01, 2'b00, 1'b0, 32'h10, 32'h0, 5'd6, 1'b1, 1'b0);

      // flush turns the instruction into a bubble
      issue(2'b00, 2'b00, 1'b0, 32'h99, 32'h0, 5'd8, 1'b1, 1'b1);
      chk("flush_dm_ena", {31'd0, dm_ena}, 32'd0);
      issue(2'b00, 2'b01, 1'b0, 32'h20, 32'h77, 5'd0, 1'b0, 1'b1);
      chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("flush_wb_reg_we", {31'd0, wb_reg_we}, 32'd0);
      chk("flush_sw_dm_ena", {31'd0, dm_ena}, 32'd0);

      // stall and flush together: stall wins, EX/MEM holds the store
      expect_wb(5'd0, 1'b0, 32'h14, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b01, 1'b0, 32'h14, 32'h99, 5'd0, 1'b0, 1'b0);
      stall = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      chk("stall_flush_dm_ena", {31'd0, dm_ena}, 32'd1);
      chk("stall_flush_dm_addr", dm_addr, 32'h14);
      stall = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      expect_wb(5'd6, 1'b1, 32'h99, 1'b0, 32'h0, 1'b1);
      issue(2'b01, 2'b00, 1'b0, 32'h14, 32'h0, 5'd6, 1'b1, 1'b0);

`ifdef MEM_FWD_EN
      expect_wb(5'd3, 1'b1, 32'h2A, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b00, 1'b0, 32'h2A, 32'h0, 5'd3, 1'b1, 1'b0);
      chk("fwd_valid_add", {31'd0, mem_fwd_valid}, 32'd1);
      chk("fwd_data_add", mem_fwd_data, 32'h2A);
      chk("fwd_rd_add", {27'd0, mem_fwd_rd}, 32'd3);
      expect_wb(5'd3, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
      issue(2'b01, 2'b00, 1'b0, 32'h08, 32'h0, 5'd3, 1'b1, 1'b0);
      chk("load_use_lw", {31'd0, mem_load_use}, 32'd1);
      chk("fwd_valid_lw", {31'd0, mem_fwd_valid}, 32'd0);
`endif

      // asynchronous reset between edges with a load in MEM
      expect_wb(5'd13, 1'b1, 32'hABC, 1'b0, 32'h0, 1'b1);
      issue(2'b00, 2'b00, 1'b0, 32'hABC, 32'h0, 5'd13, 1'b1, 1'b0);
      issue(2'b01, 2'b00, 1'b0, 32'h08, 32'h0, 5'd12, 1'b1, 1'b0);
      chk("preload_dm_ena", {31'd0, dm_ena}, 32'd1);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("async_rst_dm_ena", {31'd0, dm_ena}, 32'd0);
      chk("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("async_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("async_rst_wb_data", wb_data, 32'd0);
      chk("async_rst_wb_reg_we", {31'd0, wb_reg_we}, 32'd0);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", sbq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
